// File: rtl/tt_selftest_pkg.sv
// Shared types and constants for the I/O self-test engine.
package tt_selftest_pkg;

   typedef enum logic [1:0] {
      MODE_CNT  = 2'd0,
      MODE_WALK = 2'd1,
      MODE_LFSR = 2'd2,
      MODE_CHK  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [7:0] TAPS_DEFAULT = 8'hB8;

   function automatic logic parity32(input logic [31:0] x);
      return ^x;
   endfunction

endpackage

// File: rtl/tt_misr.sv
// Shift register with tap-mask feedback; din=0 gives a plain LFSR, otherwise a MISR.
module tt_misr
   import tt_selftest_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = seed;
      end else if (en) begin
         q_d = {q_q[WIDTH-2:0], parity32(32'(q_q & TAPS))} ^ din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/tt_io_selftest.sv
// Pattern-driven I/O self-test: issues stimulus words, compacts aligned responses into a signature.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; pass/signature hold last result
// ST_RUN   | one stimulus word issued per enabled cycle, len words total
// ST_DRAIN | waiting LAT enabled cycles for the last response capture
// ST_DONE  | one cycle: done=1, pass reflects signature==expected
module tt_io_selftest
   import tt_selftest_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter int               LAT   = 1,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [15:0]      len,
   input  logic [WIDTH-1:0] expected,
   input  logic [WIDTH-1:0] resp,
   output logic [WIDTH-1:0] stim,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   localparam int               VW    = (LAT > 0) ? LAT : 1;
   localparam logic [WIDTH-1:0] CHK_A = WIDTH'({16{2'b01}});
   localparam logic [WIDTH-1:0] CHK_B = ~CHK_A;

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [15:0]      rem_q, rem_d;
   logic [3:0]       drain_q, drain_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [VW-1:0]    vld_q, vld_d;
   logic             pass_q, pass_d;
   logic             accept;
   logic             issue;
   logic             capture;
   logic             sig_match;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] sig_q;

   assign issue     = ena && (state_q == ST_RUN);
   // With LAT=0 the response belongs to the word being issued this cycle.
   assign capture   = ena && ((LAT == 0) ? (state_q == ST_RUN) : vld_q[VW-1]);
   assign sig_match = (sig_q == expected);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      drain_d = drain_q;
      pat_d   = pat_q;
      vld_d   = vld_q;
      pass_d  = pass_q;
      accept  = 1'b0;
      if (ena) begin
         vld_d = (vld_q << 1) | VW'(issue);
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  accept = 1'b1;
                  mode_d = mode_e'(mode);
                  rem_d  = len;
                  pass_d = 1'b0;
                  case (mode_e'(mode))
                     MODE_CNT:  pat_d = '0;
                     MODE_WALK: pat_d = WIDTH'(1);
                     MODE_CHK:  pat_d = CHK_A;
                     default:   pat_d = '0;
                  endcase
                  state_d = (len == 16'd0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               rem_d = rem_q - 16'd1;
               case (mode_q)
                  MODE_CNT:  pat_d = pat_q + WIDTH'(1);
                  MODE_WALK: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                  MODE_CHK:  pat_d = (pat_q == CHK_A) ? CHK_B : CHK_A;
                  default:   pat_d = pat_q;
               endcase
               if (rem_q == 16'd1) begin
                  if (LAT == 0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_DRAIN;
                     drain_d = 4'(LAT);
                  end
               end
            end
            ST_DRAIN: begin
               drain_d = drain_q - 4'd1;
               if (drain_q == 4'd1) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               pass_d  = sig_match;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_CNT;
         rem_q   <= '0;
         drain_q <= '0;
         pat_q   <= '0;
         vld_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         drain_q <= drain_d;
         pat_q   <= pat_d;
         vld_q   <= vld_d;
         pass_q  <= pass_d;
      end
   end

   tt_misr #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .en   (issue && (mode_q == MODE_LFSR)),
      .seed (WIDTH'(1)),
      .din  ('0),
      .q    (lfsr_q)
   );

   tt_misr #(.WIDTH(WIDTH), .TAPS(TAPS)) u_sig (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .en   (capture),
      .seed (WIDTH'(1)),
      .din  (resp),
      .q    (sig_q)
   );

   assign stim      = (state_q != ST_RUN) ? '0 : ((mode_q == MODE_LFSR) ? lfsr_q : pat_q);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign pass      = (state_q == ST_DONE) ? sig_match : pass_q;
   assign signature = sig_q;

endmodule

// File: tb/tb_tt_io_selftest.sv
// Directed and randomized bench for tt_io_selftest with a timeline-level reference model.
module tb_tt_io_selftest;

   localparam int         WIDTH = 8;
   localparam int         LAT   = 1;
   localparam logic [7:0] TAPS  = 8'hB8;

   logic        clk = 1'b0;
   logic        rst, ena, start;
   logic [1:0]  mode;
   logic [15:0] len;
   logic [7:0]  expected, resp, stim, signature;
   logic        busy, done, pass;
   logic [7:0]  dev;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   tt_io_selftest #(.WIDTH(WIDTH), .LAT(LAT), .TAPS(TAPS)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .start     (start),
      .mode      (mode),
      .len       (len),
      .expected  (expected),
      .resp      (resp),
      .stim      (stim),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .signature (signature)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ena_style: 0 always on, 1 toggling starting low, 2 random.
   task automatic run(input int md, input int ln, input logic [7:0] key,
                      input bit use_model, input logic [7:0] exp_in,
                      input int ena_style, input bit noisy,
                      output int busy_cycles, output logic [7:0] sig_out);
      logic [7:0] w[$];
      logic [7:0] x, sig, exp_sig, prev_stim;
      int         e, cyc, total;
      bit         fin, cur_ena;
      w = {};
      x = 8'h01;
      for (int k = 0; k < ln; k++) begin
         case (md)
            0: w.push_back(8'(k));
            1: w.push_back(8'(1 << (k % 8)));
            2: begin
               w.push_back(x);
               x = {x[6:0], ^(x & TAPS)};
            end
            default: w.push_back((k % 2 == 0) ? 8'h55 : 8'hAA);
         endcase
      end
      sig = 8'h01;
      foreach (w[k]) sig = {sig[6:0], ^(sig & TAPS)} ^ (w[k] ^ key);
      exp_sig = use_model ? sig : exp_in;
      total   = (ln == 0) ? 0 : ln + LAT;

      @(negedge clk);
      mode      = 2'(md);
      len       = 16'(ln);
      expected  = exp_sig;
      start     = 1'b1;
      ena       = 1'b1;
      prev_stim = stim;
      cur_ena   = 1'b1;
      e = 0; cyc = 0; fin = 1'b0; busy_cycles = 0;
      while (!fin && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (cur_ena) dev = prev_stim ^ key;
         resp = dev;
         if (busy) busy_cycles++;
         if (e < ln) begin
            chk("stim_run", 32'(stim), 32'(w[e]));
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("pass_run", 32'(pass), 32'd0);
         end else if (e < total) begin
            chk("stim_drain", 32'(stim), 32'd0);
            chk("busy_drain", 32'(busy), 32'd1);
            chk("done_drain", 32'(done), 32'd0);
         end else begin
            chk("stim_done", 32'(stim), 32'd0);
            chk("busy_done", 32'(busy), 32'd0);
            chk("done_done", 32'(done), 32'd1);
            chk("pass_done", 32'(pass), 32'(sig == exp_sig));
            chk("sig_done", 32'(signature), 32'(sig));
         end
         case (ena_style)
            0:       cur_ena = 1'b1;
            1:       cur_ena = (cyc % 2 == 0);
            default: cur_ena = ($urandom % 4 != 0);
         endcase
         ena       = cur_ena;
         start     = noisy ? (($urandom % 2) == 1) : 1'b0;
         prev_stim = stim;
         if (cur_ena) begin
            if (e == total) fin = 1'b1;
            else e++;
         end
      end
      if (!fin) chk("run_timeout", 32'd0, 32'd1);
      for (int h = 0; h < 2; h++) begin
         @(negedge clk);
         start = 1'b0;
         ena   = 1'b1;
         chk("hold_done", 32'(done), 32'd0);
         chk("hold_busy", 32'(busy), 32'd0);
         chk("hold_stim", 32'(stim), 32'd0);
         chk("hold_pass", 32'(pass), 32'(sig == exp_sig));
         chk("hold_sig", 32'(signature), 32'(sig));
      end
      sig_out = sig;
   endtask

   initial begin
      int         bc;
      logic [7:0] s_cnt, s_tmp;
      rst = 1'b1; ena = 1'b0; start = 1'b0; mode = 2'd0; len = 16'd0;
      expected = 8'h00; resp = 8'h00; dev = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_stim", 32'(stim), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_sig", 32'(signature), 32'd0);
      rst = 1'b0;

      run(0, 4, 8'h00, 1'b1, 8'h00, 0, 1'b0, bc, s_cnt);
      chk("cnt_busy_len", 32'(bc), 32'd5);
      run(2, 5, 8'h00, 1'b1, 8'h00, 0, 1'b0, bc, s_tmp);
      run(1, 9, 8'h00, 1'b1, 8'h00, 0, 1'b0, bc, s_tmp);
      run(3, 3, 8'h00, 1'b1, 8'h00, 0, 1'b0, bc, s_tmp);

      run(0, 0, 8'h00, 1'b0, 8'h01, 0, 1'b0, bc, s_tmp);
      chk("len0_pass", 32'(pass), 32'd1);
      chk("len0_sig", 32'(signature), 32'h01);
      run(0, 0, 8'h00, 1'b0, 8'h02, 0, 1'b0, bc, s_tmp);
      chk("len0_fail", 32'(pass), 32'd0);

      run(0, 4, 8'h00, 1'b1, 8'h00, 1, 1'b0, bc, s_tmp);
      chk("tog_busy_len", 32'(bc), 32'd10);
      chk("tog_sig", 32'(signature), 32'(s_cnt));

      @(negedge clk);
      mode = 2'd0; len = 16'd8; expected = 8'h00; start = 1'b1; ena = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mid_w0", 32'(stim), 32'h00);
      @(negedge clk);
      chk("mid_w1", 32'(stim), 32'h01);
      @(negedge clk);
      chk("mid_w2", 32'(stim), 32'h02);
      rst = 1'b1; ena = 1'b0; start = 1'b1;
      @(negedge clk);
      chk("mid_rst_stim", 32'(stim), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_pass", 32'(pass), 32'd0);
      chk("mid_rst_sig", 32'(signature), 32'd0);
      rst = 1'b0; start = 1'b0; ena = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      run(0, 4, 8'h00, 1'b1, 8'h00, 0, 1'b0, bc, s_tmp);
      chk("post_rst_sig", 32'(signature), 32'(s_cnt));

      for (int r = 0; r < 25; r++) begin
         run(int'($urandom % 4), int'($urandom % 20), 8'($urandom),
             (($urandom % 2) == 1), 8'($urandom), 2, 1'b1, bc, s_tmp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_io_selftest.md
TT_IO_SELFTEST -- requirements
Module: tt_io_selftest

Interface
REQ-001 SHALL take parameter WIDTH, default 8: stimulus, response and signature width (4..32).
REQ-002 SHALL take parameter LAT, default 1: cycles from stimulus issue to corresponding response capture (0..15).
REQ-003 SHALL take parameter TAPS, default 8'hB8 (width WIDTH): feedback tap mask for LFSR and MISR.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ena  in  1  design-selected enable; low pauses all progress.
REQ-007 SHALL have port start  in  1  begin a test run (sampled in IDLE only).
REQ-008 SHALL have port mode  in  2  pattern: 0 counter, 1 walking-one, 2 LFSR, 3 checkerboard.
REQ-009 SHALL have port len  in  16  number of stimulus words in the run.
REQ-010 SHALL have port expected  in  WIDTH  golden signature for pass/fail.
REQ-011 SHALL have port resp  in  WIDTH  response word from device under test.
REQ-012 SHALL have port stim  out  WIDTH  stimulus word to device under test.
REQ-013 SHALL have ports busy, done, pass  out  1 each; signature  out  WIDTH.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-015 IDLE: on start=1 and ena=1, SHALL latch mode and len, seed signature to 1, go to RUN next cycle; start while not IDLE SHALL be ignored.
REQ-016 RUN: each ena=1 cycle SHALL issue one stim word; after len words go to DRAIN; len=0 SHALL skip RUN and DRAIN straight to DONE.
REQ-017 Patterns: counter 0,1,2..., wrapping at 2^WIDTH; walking-one starts 1, rotates left, wraps MSB to bit0; LFSR seeded 1, next = (x<<1)|parity(x & TAPS); checkerboard alternates 0x55.. / 0xAA.. starting 0x55...
REQ-018 Response for word k SHALL be captured exactly LAT enabled cycles after word k issued; exactly len words SHALL be captured.
REQ-019 MISR update per captured word: sig = ((sig<<1) | parity(sig & TAPS)) ^ resp.
REQ-020 DRAIN SHALL last until final capture (LAT enabled cycles; zero when LAT=0).
REQ-021 DONE SHALL last one cycle: done=1, pass=(signature==expected); then IDLE.
REQ-022 pass and signature SHALL hold until next accepted start; pass SHALL clear on accepted start.
REQ-023 busy SHALL be 1 in RUN and DRAIN, else 0.
REQ-024 ena=0 SHALL freeze FSM, pattern, latency pipeline and MISR; stim holds its value.
REQ-025 stim SHALL be 0 outside RUN.

Reset
REQ-026 rst=1 at any time, including mid-run, SHALL next cycle force IDLE, stim=0, busy=0, done=0, pass=0, signature=0, and flush the latency pipeline.
REQ-027 rst SHALL take priority over start and ena.

Structure
REQ-028 Package tt_selftest_pkg SHALL hold the mode enum, state enum, and default TAPS constant.
REQ-029 Sub-module tt_misr (WIDTH, TAPS; load, en, seed, din, q) SHALL be instantiated twice: LFSR generator (din=0) and signature compactor.
REQ-030 Latency alignment SHALL be a LAT-deep valid shift register, no response storage.

Verification (WIDTH=8, LAT=1, TAPS=8'hB8)
REQ-031 Counter, len=4, resp=stim delayed 1 -> stim 00,01,02,03; busy 5 cycles; done one cycle; signature matches model.
REQ-032 LFSR, len=5 -> stim 01,02,04,08,11.
REQ-033 Walking-one, len=9 -> stim 01,02,04,08,10,20,40,80,01; checkerboard len=3 -> 55,AA,55.
REQ-034 len=0, expected=8'h01 -> done one cycle after start, signature=01, pass=1; expected=8'h02 -> pass=0.
REQ-035 ena toggled 0/1 every cycle during counter run len=4 -> same stim sequence and signature as REQ-031, doubled duration.
REQ-036 rst asserted in RUN after 2 words -> all outputs 0 next cycle; subsequent start runs cleanly from counter value 00.
